// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master state encoding and bus widths
package apb_pkg;
  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
endpackage

// File: rtl/apb_master_timer.sv
// apb_master_timer: ACCESS-phase wait counter, flags expiry on the cycle that reaches the limit
module apb_master_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [15:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc) cnt <= cnt + 16'd1;
  assign expired = inc && cnt == 16'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB4 requester; APB_MASTER_TIMEOUT_EN adds an ACCESS-phase timeout
module apb_master import apb_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic                  req_write,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic                  pwrite,
  output logic [APB_DATA_W-1:0] pwdata,
  output logic [3:0]            pwstrb,
  input  logic                  pready,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pslverr
);
  apb_state_e state, state_n;
  logic wr_q, err_q, tmo;
  logic [APB_DATA_W-1:0] rdata_q;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end
`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == SETUP),
    .inc    (state == ACCESS && !pready),
    .expired(tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = req_valid ? SETUP : IDLE;
      SETUP:   state_n = ACCESS;
      ACCESS:  state_n = (pready || tmo) ? RESP : ACCESS;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      paddr   <= '0;
      pwdata  <= '0;
      pwstrb  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        paddr  <= req_addr;
        wr_q   <= req_write;
        pwdata <= req_write ? req_wdata : '0;
        pwstrb <= req_write ? req_wstrb : '0;
      end
      // a timeout completes the access as an error with no data
      if (state == ACCESS && (pready || tmo)) begin
        rdata_q <= (pready && !wr_q && !pslverr) ? prdata : '0;
        err_q   <= pready ? pslverr : 1'b1;
      end
    end
  end
  assign req_ready = state == IDLE && !rst;
  assign psel      = state == SETUP || state == ACCESS;
  assign penable   = state == ACCESS;
  assign pwrite    = psel && wr_q;
  assign rsp_valid = state == RESP;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the max ACCESS-phase wait in cycles (range 1..65535).
REQ-002 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted when req_valid is also high.
REQ-007 req_addr  input  12  byte address.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_wstrb  input  4  write byte strobes.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid is also high.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  pslverr or timeout.
REQ-015 psel, penable, paddr[11:0], pwrite, pwdata[31:0], pwstrb[3:0]  output  APB4 requester signals.
REQ-016 pready, prdata[31:0], pslverr  input  APB4 completer signals.

Function
REQ-017 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-018 IDLE: req_ready=1; on req_valid, latch addr/write/wdata/wstrb and move to SETUP.
REQ-019 SETUP: psel=1, penable=0; SHALL move unconditionally to ACCESS next cycle.
REQ-020 ACCESS: psel=1, penable=1; on pready=1, capture prdata (reads only) and pslverr, then move to RESP.
REQ-021 RESP: rsp_valid=1 with outputs held stable; on rsp_ready, move to IDLE; psel=penable=0.
REQ-022 req_ready SHALL be 0 in every state except IDLE, so at most one transaction is outstanding.
REQ-023 Minimum latency: request accepted at cycle 0, SETUP at 1, ACCESS at 2, pready=1 at 2, rsp_valid at 3; back-to-back requests SHALL take 4 cycles each with rsp_ready held high.
REQ-024 paddr, pwrite, pwdata and pwstrb SHALL be driven from latched values and stay stable from SETUP until ACCESS completes.
REQ-025 pwstrb SHALL be 4'b0000 for reads, and pwdata SHALL be 0 for reads.
REQ-026 Outside SETUP/ACCESS, paddr/pwdata/pwstrb SHALL hold their last values, and pwrite=0.
REQ-027 pslverr and prdata SHALL be sampled only when psel&penable&pready are all high; otherwise they are ignored.
REQ-028 If pslverr=1 on a read, rsp_rdata SHALL be 0 and rsp_err SHALL be 1.
REQ-029 Changes on req_* while not in IDLE SHALL be ignored.

Reset
REQ-030 When rst=1, the FSM SHALL go to IDLE and all outputs SHALL be 0, except req_ready=1 on the first cycle after rst deasserts.
REQ-031 Reset in SETUP/ACCESS/RESP SHALL drop psel/penable on the next edge and discard the in-flight transaction and its response.

Configuration
REQ-032 Macro APB_MASTER_TIMEOUT_EN, when defined: a 16-bit counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0.
REQ-033 When the counter reaches TIMEOUT_CYCLES, the block SHALL drop psel/penable, enter RESP with rsp_err=1 and rsp_rdata=0, and ignore any later pready.
REQ-034 Without the macro, ACCESS SHALL wait indefinitely, TIMEOUT_CYCLES SHALL have no effect, and no counter logic SHALL exist.

Structure
REQ-035 The shared package apb_pkg SHALL hold the apb_state_e enum (IDLE, SETUP, ACCESS, RESP) and constants APB_ADDR_W=12 and APB_DATA_W=32.
REQ-036 The timeout counter SHALL be the sole sub-module, apb_master_timer, instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-037 Read 0x008 with a zero-wait completer, prdata=0xA5A5_1234 -> SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3 with rsp_rdata=0xA5A5_1234 and rsp_err=0.
REQ-038 Write 0x00C, wdata=0x55, wstrb=4'b0001, completer inserts 3 wait states -> paddr/pwdata/pwstrb stable across all 4 ACCESS cycles; rsp_err=0 and rsp_rdata=0.
REQ-039 Read with pslverr=1 and prdata=0xFFFF_FFFF -> rsp_err=1 and rsp_rdata=0; pwstrb=0 throughout.
REQ-040 rsp_ready held low for 5 cycles after rsp_valid -> response held stable, req_ready=0, and a new req_valid is not accepted until the response handshake completes.
REQ-041 rst=1 asserted during ACCESS -> psel=penable=0 and rsp_valid=0 next cycle, req_ready=1 after rst deasserts.
REQ-042 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held at 0 -> psel drops after 4 ACCESS cycles, rsp_err=1, and a late pready is ignored.
